// File: rtl/ascon_cfg.sv
// Shared ASCON front-end configuration: BD type codes and key staging FSM states.
package ascon_cfg;

  localparam logic [2:0] D_NULL  = 3'd0;
  localparam logic [2:0] D_NONCE = 3'd1;
  localparam logic [2:0] D_AD    = 3'd2;
  localparam logic [2:0] D_MSG   = 3'd3;
  localparam logic [2:0] D_TAG   = 3'd4;

  typedef logic [1:0] key_state_t;
  localparam key_state_t S_EMPTY = 2'd0;
  localparam key_state_t S_FILL  = 2'd1;
  localparam key_state_t S_FULL  = 2'd2;

endpackage

// File: rtl/word_assembler.sv
// Shifts WORD_W-bit words into a TOTAL_W-bit register, MS word first, counting words.
module word_assembler #(
  parameter int WORD_W  = 32,
  parameter int TOTAL_W = 160,
  localparam int WORDS  = TOTAL_W / WORD_W,
  localparam int CNT_W  = $clog2(WORDS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               shift,
  input  logic               clear,
  input  logic [WORD_W-1:0]  word,
  output logic [TOTAL_W-1:0] data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [TOTAL_W-1:0] base;
  logic [TOTAL_W-1:0] shifted;

  // clear together with shift restarts the register with this word as the first one
  assign base = clear ? '0 : data;

  generate
    if (WORDS == 1) begin : g_single
      assign shifted = word;
    end else begin : g_multi
      assign shifted = {base[TOTAL_W-WORD_W-1:0], word};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data  <= '0;
      count <= '0;
    end else if (shift) begin
      data  <= shifted;
      count <= clear ? CNT_W'(1) : count + 1'b1;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end
  end

  assign full = (count == CNT_W'(WORDS));

endmodule

// File: rtl/key_nonce_loader.sv
// ASCON key/nonce capture: staged key with preload, running key, nonce capture and word-count checks.
module key_nonce_loader
  import ascon_cfg::*;
#(
  parameter int WORD_W  = 32,
  parameter int KEY_W   = 160,
  parameter int NONCE_W = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               key_valid_i,
  input  logic               key_last_i,
  input  logic [WORD_W-1:0]  key_i,
  output logic               key_ready_o,
  input  logic               bd_valid_i,
  input  logic               bd_ready_i,
  input  logic [2:0]         bd_type_i,
  input  logic [WORD_W-1:0]  bd_i,
  input  logic               eoi_i,
  input  logic               ready_i,
  input  logic               idle_state_i,
  input  logic               almost_done_i,
  input  logic               key_reuse_i,
  output logic               run_key_vld_o,
  output logic [KEY_W-1:0]   run_key_o,
  output logic               nonce_vld_o,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               key_err_o,
  output logic               nonce_err_o
);

  localparam int KEY_WORDS   = KEY_W / WORD_W;
  localparam int NONCE_WORDS = NONCE_W / WORD_W;
  localparam int KCW         = $clog2(KEY_WORDS + 1);
  localparam int NCW         = $clog2(NONCE_WORDS + 1);

  key_state_t         state, state_nxt;
  logic [KEY_W-1:0]   stage;
  logic [KCW-1:0]     kcount;
  logic [NCW-1:0]     ncount;
  logic               kfull, nfull;
  logic               key_acc, key_pos_last, key_bad, key_done;
  logic               pass, start, nd, kshift, kclear, nshift;

  assign key_ready_o  = (state != S_FULL);
  assign key_acc      = key_valid_i & key_ready_o;
  assign key_pos_last = (kcount == KCW'(KEY_WORDS - 1));
  // short key (last too early) and long key (no last at final slot) both reduce to a mismatch
  assign key_bad      = key_acc & (key_last_i ^ key_pos_last);
  assign key_done     = key_acc & key_last_i & key_pos_last;
  assign pass         = (state == S_FULL) & kfull & (idle_state_i | almost_done_i);
  assign start        = eoi_i & ready_i;
  assign nd           = bd_valid_i & bd_ready_i & (bd_type_i == D_NONCE);

  assign kshift = key_acc & ~key_bad;
  assign kclear = key_bad | pass;
  // a message start frees the nonce slot in the same cycle a new word arrives
  assign nshift = nd & (start | ~nfull);

  word_assembler #(.WORD_W(WORD_W), .TOTAL_W(KEY_W)) u_key_stage (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .shift (kshift),
    .clear (kclear),
    .word  (key_i),
    .data  (stage),
    .count (kcount),
    .full  (kfull)
  );

  word_assembler #(.WORD_W(WORD_W), .TOTAL_W(NONCE_W)) u_nonce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .shift (nshift),
    .clear (start),
    .word  (bd_i),
    .data  (nonce_o),
    .count (ncount),
    .full  (nfull)
  );

  assign nonce_vld_o = nfull;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY, S_FILL: begin
        if (key_bad)       state_nxt = S_EMPTY;
        else if (key_done) state_nxt = S_FULL;
        else if (key_acc)  state_nxt = S_FILL;
      end
      S_FULL:  if (pass) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_EMPTY;
      run_key_o     <= '0;
      run_key_vld_o <= 1'b0;
      key_err_o     <= 1'b0;
      nonce_err_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_err_o   <= key_bad;
      nonce_err_o <= nd & ~start & (ncount == NCW'(NONCE_WORDS));
      if (pass) begin
        run_key_o     <= stage;
        run_key_vld_o <= 1'b1;
      end else if (start & ~key_reuse_i) begin
        run_key_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_nonce_loader.sv
// Randomized and directed bench for key_nonce_loader against a queue-based reference model.
module tb_key_nonce_loader;
  import ascon_cfg::*;

  localparam int KW = 5;
  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         rst_i, key_valid_i, key_last_i, key_ready_o;
  logic [31:0]  key_i, bd_i;
  logic         bd_valid_i, bd_ready_i;
  logic [2:0]   bd_type_i;
  logic         eoi_i, ready_i, idle_state_i, almost_done_i, key_reuse_i;
  logic         run_key_vld_o, nonce_vld_o, key_err_o, nonce_err_o;
  logic [159:0] run_key_o;
  logic [127:0] nonce_o;

  key_nonce_loader #(.WORD_W(32), .KEY_W(160), .NONCE_W(128)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .key_valid_i(key_valid_i), .key_last_i(key_last_i), .key_i(key_i), .key_ready_o(key_ready_o),
    .bd_valid_i(bd_valid_i), .bd_ready_i(bd_ready_i), .bd_type_i(bd_type_i), .bd_i(bd_i),
    .eoi_i(eoi_i), .ready_i(ready_i), .idle_state_i(idle_state_i), .almost_done_i(almost_done_i),
    .key_reuse_i(key_reuse_i), .run_key_vld_o(run_key_vld_o), .run_key_o(run_key_o),
    .nonce_vld_o(nonce_vld_o), .nonce_o(nonce_o), .key_err_o(key_err_o), .nonce_err_o(nonce_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: words held as queues, outputs derived from queue sizes
  logic [31:0]  kq[$];
  logic [31:0]  nq[$];
  bit           m_kfull, m_run_vld, m_kerr, m_nerr;
  logic [159:0] m_run_key;
  bit           chk_en = 1'b0;

  function automatic logic [159:0] pack(input logic [31:0] q[$]);
    logic [159:0] r = '0;
    foreach (q[i]) r = (r << 32) | 160'(q[i]);
    return r;
  endfunction

  task automatic compare_outputs();
    chk("key_ready", 160'(key_ready_o), 160'(!m_kfull));
    chk("run_key_vld", 160'(run_key_vld_o), 160'(m_run_vld));
    chk("run_key", run_key_o, m_run_key);
    chk("nonce_vld", 160'(nonce_vld_o), 160'(nq.size() == NW));
    chk("nonce", 160'(nonce_o), pack(nq));
    chk("key_err", 160'(key_err_o), 160'(m_kerr));
    chk("nonce_err", 160'(nonce_err_o), 160'(m_nerr));
  endtask

  task automatic model_edge();
    bit acc, pass, start, nd;
    if (rst_i) begin
      kq.delete(); nq.delete();
      m_kfull = 0; m_run_vld = 0; m_kerr = 0; m_nerr = 0; m_run_key = '0;
      return;
    end
    acc   = key_valid_i && !m_kfull;
    pass  = m_kfull && (idle_state_i || almost_done_i);
    start = eoi_i && ready_i;
    nd    = bd_valid_i && bd_ready_i && (bd_type_i == D_NONCE);
    m_kerr = 0;
    m_nerr = 0;
    if (pass) begin
      m_run_key = pack(kq);
      m_run_vld = 1;
      kq.delete();
      m_kfull = 0;
    end else if (start && !key_reuse_i) begin
      m_run_vld = 0;
    end
    if (acc) begin
      kq.push_back(key_i);
      if (kq.size() == KW && key_last_i) m_kfull = 1;
      else if (kq.size() == KW || key_last_i) begin
        m_kerr = 1;
        kq.delete();
      end
    end
    if (start) nq.delete();
    if (nd) begin
      if (nq.size() < NW) nq.push_back(bd_i);
      else m_nerr = 1;
    end
  endtask

  // inputs change at posedge+1; outputs compared and model stepped at the negedge
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    key_valid_i = 0; key_last_i = 0; key_i = '0;
    bd_valid_i = 0; bd_ready_i = 0; bd_type_i = D_NULL; bd_i = '0;
    eoi_i = 0; ready_i = 0; idle_state_i = 0; almost_done_i = 0; key_reuse_i = 0;
  endtask

  task automatic key_word(input logic [31:0] w, input logic last);
    key_valid_i = 1; key_i = w; key_last_i = last;
    tick();
    key_valid_i = 0; key_last_i = 0;
  endtask

  task automatic nonce_word(input logic [31:0] w);
    bd_valid_i = 1; bd_ready_i = 1; bd_type_i = D_NONCE; bd_i = w;
    tick();
    bd_valid_i = 0; bd_ready_i = 0; bd_type_i = D_NULL;
  endtask

  logic [159:0] key_a, exp_b;
  logic [31:0]  kb[KW];

  initial begin
    clr_in();
    rst_i = 1;
    tick();
    chk_en = 1;
    tick();
    chk("rst_key_ready", 160'(key_ready_o), 160'(1));
    chk("rst_run_vld", 160'(run_key_vld_o), 160'(0));
    chk("rst_run_key", run_key_o, 160'(0));
    chk("rst_nonce", 160'({nonce_vld_o, nonce_o}), 160'(0));
    chk("rst_errs", 160'({key_err_o, nonce_err_o}), 160'(0));
    rst_i = 0;
    tick();

    // key A with idle core: valid two cycles after last word
    key_a = 160'h00010203_04050607_08090a0b_0c0d0e0f_10111213;
    idle_state_i = 1;
    for (int i = 0; i < KW; i++) key_word(32'h00010203 + 32'(i) * 32'h04040404, i == KW - 1);
    chk("a_ready_low", 160'(key_ready_o), 160'(0));
    chk("a_vld_not_yet", 160'(run_key_vld_o), 160'(0));
    tick();
    chk("a_run_vld", 160'(run_key_vld_o), 160'(1));
    chk("a_run_key", run_key_o, key_a);
    chk("a_ready_back", 160'(key_ready_o), 160'(1));

    // preload B while core busy, swap on almost_done
    idle_state_i = 0;
    exp_b = '0;
    for (int i = 0; i < KW; i++) begin
      kb[i] = $urandom;
      exp_b = (exp_b << 32) | 160'(kb[i]);
      key_word(kb[i], i == KW - 1);
    end
    repeat (3) tick();
    chk("b_ready_low", 160'(key_ready_o), 160'(0));
    chk("b_keeps_a", run_key_o, key_a);
    almost_done_i = 1;
    tick();
    almost_done_i = 0;
    chk("b_swapped", run_key_o, exp_b);
    tick();

    // short key, then long key, then a correct key
    idle_state_i = 1;
    for (int i = 0; i < 3; i++) key_word($urandom, i == 2);
    chk("short_err", 160'(key_err_o), 160'(1));
    tick();
    chk("short_err_once", 160'(key_err_o), 160'(0));
    chk("short_ready", 160'(key_ready_o), 160'(1));
    for (int i = 0; i < KW; i++) key_word($urandom, 1'b0);
    chk("long_err", 160'(key_err_o), 160'(1));
    tick();
    chk("long_err_once", 160'(key_err_o), 160'(0));
    exp_b = '0;
    for (int i = 0; i < KW; i++) begin
      kb[i] = $urandom;
      exp_b = (exp_b << 32) | 160'(kb[i]);
      key_word(kb[i], i == KW - 1);
    end
    tick();
    chk("after_err_key", run_key_o, exp_b);
    idle_state_i = 0;

    // nonce capture and overflow
    for (int i = 0; i < NW; i++) nonce_word(32'hA0 + 32'(i));
    chk("nonce_vld", 160'(nonce_vld_o), 160'(1));
    chk("nonce_val", 160'(nonce_o), 160'(128'h000000A0_000000A1_000000A2_000000A3));
    nonce_word(32'hA4);
    chk("nonce_ovf_err", 160'(nonce_err_o), 160'(1));
    chk("nonce_ovf_keep", 160'(nonce_o), 160'(128'h000000A0_000000A1_000000A2_000000A3));

    // start without reuse drops the key; start with reuse keeps it
    eoi_i = 1; ready_i = 1; key_reuse_i = 0;
    tick();
    eoi_i = 0; ready_i = 0;
    chk("start_noreuse", 160'(run_key_vld_o), 160'(0));
    chk("start_nonce_clr", 160'({nonce_vld_o, nonce_o}), 160'(0));
    idle_state_i = 1;
    for (int i = 0; i < KW; i++) key_word($urandom, i == KW - 1);
    tick();
    idle_state_i = 0;
    eoi_i = 1; ready_i = 1; key_reuse_i = 1;
    nonce_word(32'h55);
    eoi_i = 0; ready_i = 0; key_reuse_i = 0;
    chk("start_reuse", 160'(run_key_vld_o), 160'(1));
    chk("start_nonce_55", 160'(nonce_o), 160'(32'h55));
    chk("start_nonce_partial", 160'(nonce_vld_o), 160'(0));

    // reset mid-key, then a fresh key
    key_word(32'hDEAD0000, 1'b0);
    key_word(32'hDEAD0001, 1'b0);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("mid_rst_ready", 160'(key_ready_o), 160'(1));
    chk("mid_rst_outs", 160'({run_key_vld_o, nonce_vld_o, key_err_o, nonce_err_o}), 160'(0));
    chk("mid_rst_data", run_key_o | 160'(nonce_o), 160'(0));
    idle_state_i = 1;
    exp_b = '0;
    for (int i = 0; i < KW; i++) begin
      kb[i] = $urandom;
      exp_b = (exp_b << 32) | 160'(kb[i]);
      key_word(kb[i], i == KW - 1);
    end
    tick();
    chk("fresh_key", run_key_o, exp_b);
    chk("fresh_vld", 160'(run_key_vld_o), 160'(1));

    // randomized traffic, compared every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      key_valid_i   = ($urandom_range(0, 3) != 0);
      key_i         = $urandom;
      key_last_i    = (kq.size() == KW - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      bd_valid_i    = $urandom_range(0, 1);
      bd_ready_i    = ($urandom_range(0, 3) != 0);
      bd_type_i     = $urandom_range(0, 1) ? D_NONCE : 3'($urandom_range(0, 7));
      bd_i          = $urandom;
      eoi_i         = ($urandom_range(0, 3) == 0);
      ready_i       = ($urandom_range(0, 2) == 0);
      idle_state_i  = ($urandom_range(0, 3) == 0);
      almost_done_i = ($urandom_range(0, 5) == 0);
      key_reuse_i   = $urandom_range(0, 1);
      rst_i         = ($urandom_range(0, 299) == 0);
      tick();
    end
    clr_in();
    rst_i = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
